// File: rtl/collatz_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | collatz / collatz_sched : multi-lane Collatz range sweep into result RAM |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

module collatz (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [31:0] n,
  output logic [31:0] dout
);
  logic [31:0] r_dout;

  // Holds at 1 once reached so the lane sees a stable done.
  always_ff @(posedge clk) begin
    if (reset)
      r_dout <= 32'd0;
    else if (go)
      r_dout <= n;
    else if (r_dout != 32'd1)
      r_dout <= r_dout[0] ? (r_dout + (r_dout << 1) + 32'd1) : (r_dout >> 1);
  end

  assign dout = r_dout;
endmodule

module collatz_sched #(
  parameter int LANES         = 2,
  parameter int RAM_WORDS     = 16,
  parameter int RAM_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [31:0]              start,
  input  logic [RAM_ADDR_BITS-1:0] addr,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              count
);
  localparam int            c_IW    = RAM_ADDR_BITS + 1;
  localparam int            c_LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [c_IW-1:0] c_WORDS = c_IW'(RAM_WORDS);
  localparam logic [15:0]   c_WDOG  = 16'hFFFE;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [1:0] L_IDLE = 2'd0;
  localparam logic [1:0] L_LOAD = 2'd1;
  localparam logic [1:0] L_RUN  = 2'd2;
  localparam logic [1:0] L_WB   = 2'd3;

  logic [1:0]               r_top;
  logic [31:0]              r_base;
  logic [c_IW-1:0]          r_next_idx;
  logic [c_IW-1:0]          r_written;
  logic                     r_busy;
  logic                     r_done;

  logic [1:0]               r_lst  [LANES];
  logic                     r_lgo  [LANES];
  logic [31:0]              r_ln   [LANES];
  logic [15:0]              r_lcnt [LANES];
  logic [15:0]              r_lres [LANES];
  logic [RAM_ADDR_BITS-1:0] r_lidx [LANES];
  logic [31:0]              w_dout [LANES];
  logic                     w_idone[LANES];

  logic [15:0]              r_mem [2**RAM_ADDR_BITS];

  logic                     w_disp_ok;
  logic [c_LW-1:0]          w_disp_lane;
  logic                     w_wb_ok;
  logic [c_LW-1:0]          w_wb_lane;
  logic [RAM_ADDR_BITS-1:0] w_wb_idx;
  logic [15:0]              w_wb_res;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    collatz u_iter (
      .clk   (clk),
      .reset (reset),
      .go    (r_lgo[g]),
      .n     (r_ln[g]),
      .dout  (w_dout[g])
    );
    assign w_idone[g] = (w_dout[g] == 32'd1);
  end

  // Descending scan so the lowest-index candidate is the one left standing.
  always_comb begin
    w_disp_ok   = 1'b0;
    w_disp_lane = '0;
    w_wb_ok     = 1'b0;
    w_wb_lane   = '0;
    w_wb_idx    = '0;
    w_wb_res    = 16'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (r_lst[i] == L_IDLE) begin
        w_disp_ok   = 1'b1;
        w_disp_lane = c_LW'(i);
      end
      if (r_lst[i] == L_WB) begin
        w_wb_ok   = 1'b1;
        w_wb_lane = c_LW'(i);
        w_wb_idx  = r_lidx[i];
        w_wb_res  = r_lres[i];
      end
    end
    w_disp_ok = w_disp_ok && (r_top == S_RUN) && (r_next_idx < c_WORDS);
    w_wb_ok   = w_wb_ok && (r_top == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_top      <= S_IDLE;
      r_base     <= 32'd0;
      r_next_idx <= '0;
      r_written  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_lst[i]  <= L_IDLE;
        r_lgo[i]  <= 1'b0;
        r_ln[i]   <= 32'd0;
        r_lcnt[i] <= 16'd0;
        r_lres[i] <= 16'd0;
        r_lidx[i] <= '0;
      end
    end else if (go) begin
      r_top      <= S_RUN;
      r_base     <= start;
      r_next_idx <= '0;
      r_written  <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_lst[i] <= L_IDLE;
        r_lgo[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LANES; i++)
        r_lgo[i] <= 1'b0;
      if (r_top == S_RUN) begin
        if (r_written == c_WORDS) begin
          r_top  <= S_FIN;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        for (int i = 0; i < LANES; i++) begin
          case (r_lst[i])
            L_IDLE: begin
              if (w_disp_ok && (c_LW'(i) == w_disp_lane)) begin
                r_lst[i]  <= L_LOAD;
                r_lgo[i]  <= 1'b1;
                r_ln[i]   <= r_base + {{(32 - c_IW){1'b0}}, r_next_idx};
                r_lcnt[i] <= 16'd0;
                r_lidx[i] <= r_next_idx[RAM_ADDR_BITS-1:0];
              end
            end
            L_LOAD: r_lst[i] <= L_RUN;
            L_RUN: begin
              if (w_idone[i]) begin
                r_lres[i] <= r_lcnt[i] + 16'd1;
                r_lst[i]  <= L_WB;
              end else if (r_lcnt[i] == c_WDOG) begin
                r_lres[i] <= 16'hFFFF;
                r_lst[i]  <= L_WB;
              end else begin
                r_lcnt[i] <= r_lcnt[i] + 16'd1;
              end
            end
            L_WB: begin
              if (w_wb_ok && (c_LW'(i) == w_wb_lane))
                r_lst[i] <= L_IDLE;
            end
            default: r_lst[i] <= L_IDLE;
          endcase
        end
        if (w_disp_ok)
          r_next_idx <= r_next_idx + c_IW'(1);
        if (w_wb_ok)
          r_written <= r_written + c_IW'(1);
      end
    end
  end

  // A restarting go drops any write landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset && !go && w_wb_ok)
      r_mem[w_wb_idx] <= w_wb_res;
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign count = r_done ? r_mem[addr] : 16'd0;
endmodule

`default_nettype wire

// File: tb/tb_collatz_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_collatz_sched : scoreboard bench over LANES=1/2/4 copies of the sweep |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_collatz_sched;
  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        go    = 1'b0;
  logic [31:0] start = 32'd0;
  logic [3:0]  addr  = 4'd0;
  logic        busy  [3];
  logic        done  [3];
  logic [15:0] count [3];

  int n_checks = 0;
  int n_fail   = 0;
  int lanes_of [3] = '{1, 2, 4};
  int t_done   [3] = '{0, 0, 0};

  typedef struct {
    int a;
    int v;
    bit last;
  } exp_t;
  exp_t sbq[$];
  bit   mon_busy = 1'b0;

  int exp1  [16] = '{1, 2, 8, 3, 6, 9, 17, 4, 20, 7, 15, 10, 10, 18, 18, 5};
  int exp27 [16] = '{112, 19, 19, 19, 107, 6, 27, 14, 14, 22, 22, 22, 35, 9, 110, 9};
  int exp12 [16] = '{10, 10, 18, 18, 5, 13, 21, 21, 8, 8, 16, 16, 11, 24, 11, 112};
  int exp0  [16] = '{65535, 1, 2, 8, 3, 6, 9, 17, 4, 20, 7, 15, 10, 10, 18, 18};

  collatz_sched #(.LANES(1), .RAM_WORDS(16), .RAM_ADDR_BITS(4)) u_l1 (
    .clk(clk), .reset(reset), .go(go), .start(start), .addr(addr),
    .busy(busy[0]), .done(done[0]), .count(count[0]));
  collatz_sched #(.LANES(2), .RAM_WORDS(16), .RAM_ADDR_BITS(4)) u_l2 (
    .clk(clk), .reset(reset), .go(go), .start(start), .addr(addr),
    .busy(busy[1]), .done(done[1]), .count(count[1]));
  collatz_sched #(.LANES(4), .RAM_WORDS(16), .RAM_ADDR_BITS(4)) u_l4 (
    .clk(clk), .reset(reset), .go(go), .start(start), .addr(addr),
    .busy(busy[2]), .done(done[2]), .count(count[2]));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: once every copy reports done, read back and retire queued results.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0 && done[0] && done[1] && done[2]) begin
        mon_busy = 1'b1;
        do begin
          e    = sbq.pop_front();
          addr = e.a[3:0];
          #1;
          for (int k = 0; k < 3; k++)
            check($sformatf("mem[%0d] lanes=%0d", e.a, lanes_of[k]), int'(count[k]), e.v);
          @(negedge clk);
        end while (!e.last);
        mon_busy = 1'b0;
      end
    end
  end

  task automatic issue_go(input logic [31:0] s);
    @(posedge clk); #1;
    start = s;
    go    = 1'b1;
    @(posedge clk); #1;
    go    = 1'b0;
  endtask

  task automatic push_table(input int vals[16]);
    for (int a = 0; a < 16; a++)
      sbq.push_back('{a: a, v: vals[a], last: (a == 15)});
  endtask

  task automatic wait_sweep(input string name, input int budget);
    int cyc = 0;
    int nseen;
    bit seen[3] = '{1'b0, 1'b0, 1'b0};
    while (!(seen[0] && seen[1] && seen[2]) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 3; k++)
        if (done[k] && !seen[k]) begin
          seen[k]   = 1'b1;
          t_done[k] = cyc;
        end
    end
    nseen = int'(seen[0]) + int'(seen[1]) + int'(seen[2]);
    check({name, " copies finished"}, nseen, 3);
    cyc = 0;
    while ((sbq.size() > 0 || mon_busy) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " scoreboard drained"}, sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin : stimulus
    int hold;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset busy lanes=%0d", lanes_of[k]), int'(busy[k]), 0);
      check($sformatf("reset done lanes=%0d", lanes_of[k]), int'(done[k]), 0);
    end
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        check($sformatf("reset count[%0d] lanes=%0d", a, lanes_of[k]), int'(count[k]), 0);
    end

    issue_go(32'd1);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("busy after go lanes=%0d", lanes_of[k]), int'(busy[k]), 1);
    push_table(exp1);
    wait_sweep("start=1", 3000);
    check("lanes=4 finishes before lanes=1", int'(t_done[2] < t_done[0]), 1);
    hold = 0;
    repeat (100) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (done[k]) hold++;
    end
    check("done held 100 cycles x3", hold, 300);

    issue_go(32'd27);
    push_table(exp27);
    wait_sweep("start=27", 4000);

    issue_go(32'd12);
    push_table(exp12);
    wait_sweep("start=12", 3000);

    issue_go(32'd1);
    repeat (8) @(posedge clk);
    issue_go(32'd100);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("restart done low lanes=%0d", lanes_of[k]), int'(done[k]), 0);
      check($sformatf("restart busy lanes=%0d", lanes_of[k]), int'(busy[k]), 1);
    end
    sbq.push_back('{a: 0, v: 26, last: 1'b0});
    sbq.push_back('{a: 1, v: 26, last: 1'b0});
    sbq.push_back('{a: 2, v: 26, last: 1'b0});
    sbq.push_back('{a: 4, v: 13, last: 1'b1});
    wait_sweep("start=100", 4000);

    issue_go(32'd1);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mid reset busy lanes=%0d", lanes_of[k]), int'(busy[k]), 0);
      check($sformatf("mid reset done lanes=%0d", lanes_of[k]), int'(done[k]), 0);
      check($sformatf("mid reset count lanes=%0d", lanes_of[k]), int'(count[k]), 0);
    end

    issue_go(32'd0);
    push_table(exp0);
    wait_sweep("start=0 watchdog", 70000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
